// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: memory, IR and branch signals of the fetch unit
interface instr_fetch_unit_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 24
);
  logic [AddrWidth-1:0] MemAddr;
  logic                 MemRdReq;
  logic                 MemAck;
  logic [DataWidth-1:0] MemDataIn;
  logic [DataWidth-1:0] IRDataOut;
  logic                 IRInEn;
  logic                 IRReady;
  logic                 BranchEn;
  logic [AddrWidth-1:0] BranchAddr;
  logic [AddrWidth-1:0] PCOut;
  modport master (
    output MemAddr, MemRdReq, IRDataOut, IRInEn, PCOut,
    input  MemAck, MemDataIn, IRReady, BranchEn, BranchAddr
  );
  modport slave (
    input  MemAddr, MemRdReq, IRDataOut, IRInEn, PCOut,
    output MemAck, MemDataIn, IRReady, BranchEn, BranchAddr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, req/ack program fetch, word buffer and IR load strobe
// IFETCH_PREFETCH_EN selects a 2-entry buffer instead of a single word
module instr_fetch_unit #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 24,
  parameter logic [AddrWidth-1:0] ResetVector = '0,
  parameter logic [AddrWidth-1:0] AddrInc = AddrWidth'(1)
) (
  input logic clock,
  input logic reset,
  instr_fetch_unit_if.master f
);
`ifdef IFETCH_PREFETCH_EN
  localparam logic [1:0] Depth = 2'd2;
`else
  localparam logic [1:0] Depth = 2'd1;
`endif
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [DataWidth-1:0] b0_q, b0_d, b1_q, b1_d, ir_data_q, ir_data_d;
  logic [1:0] cnt_q, cnt_d;
  logic req_q, req_d, ir_en_q, ir_en_d, disc_q, disc_d;
  logic full, pop, push, wr1;
  always_comb begin
    full = cnt_q == Depth;
    pop = (cnt_q != 2'd0) && f.IRReady && !f.BranchEn;
    push = (state_q == FETCH) && f.MemAck && !disc_q && !f.BranchEn;
    wr1 = (cnt_q - {1'b0, pop}) != 2'd0;
    ir_en_d = pop;
    ir_data_d = pop ? b0_q : ir_data_q;
    cnt_d = f.BranchEn ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    b0_d = (push && !wr1) ? f.MemDataIn : pop ? b1_q : b0_q;
    b1_d = (push && wr1) ? f.MemDataIn : b1_q;
    state_d = state_q;
    req_d = req_q;
    addr_d = addr_q;
    pc_d = f.BranchEn ? f.BranchAddr : pc_q;
    disc_d = disc_q;
    if (state_q == IDLE) begin
      if (!full || f.BranchEn) begin
        state_d = FETCH;
        req_d = 1'b1;
        addr_d = f.BranchEn ? f.BranchAddr : pc_q;
      end
    end else if (f.MemAck) begin
      state_d = IDLE;
      req_d = 1'b0;
      disc_d = 1'b0;
      // a discarded fetch leaves PC at the branch target
      pc_d = f.BranchEn ? f.BranchAddr : disc_q ? pc_q : pc_q + AddrInc;
    end else if (f.BranchEn) begin
      disc_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= ResetVector;
      addr_q <= '0;
      req_q <= 1'b0;
      disc_q <= 1'b0;
      cnt_q <= 2'd0;
      b0_q <= '0;
      b1_q <= '0;
      ir_en_q <= 1'b0;
      ir_data_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      req_q <= req_d;
      disc_q <= disc_d;
      cnt_q <= cnt_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      ir_en_q <= ir_en_d;
      ir_data_q <= ir_data_d;
    end
  end
  assign f.MemAddr = addr_q;
  assign f.MemRdReq = req_q;
  assign f.IRDataOut = ir_data_q;
  assign f.IRInEn = ir_en_q;
  assign f.PCOut = pc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboarded memory responder driving instr_fetch_unit
module tb_instr_fetch_unit;
`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  instr_fetch_unit_if f ();
  instr_fetch_unit_if g ();
  instr_fetch_unit dut (.clock(clock), .reset(reset), .f(f));
  instr_fetch_unit #(.ResetVector(24'hFF_FFFF)) dut5 (.clock(clock), .reset(reset), .f(g));
  int n_chk = 0, n_pass = 0, ack_cnt = 0, deliv = 0;
  logic auto_ack = 1'b0, drop = 1'b0;
  logic [31:0] exp_q[$];
  logic [23:0] addr_log[$], g_log[$];
  logic [31:0] last_ir = '0;
  function automatic logic [31:0] word(input logic [23:0] a);
    return {a[7:0] ^ 8'hA5, a};
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask
  // the second instance only needs an always-acking memory and an address log
  always @(negedge clock) begin
    g.MemAck = g.MemRdReq;
    g.MemDataIn = '0;
    if (g.MemRdReq && !reset) g_log.push_back(g.MemAddr);
  end
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    if (f.IRInEn) begin
      deliv++;
      last_ir = f.IRDataOut;
      if (exp_q.size() == 0) chk("ir_spurious", 32'd1, 32'd0);
      else chk("ir_word", f.IRDataOut, exp_q.pop_front());
    end
    f.MemAck = auto_ack && f.MemRdReq;
    f.MemDataIn = word(f.MemAddr);
    if (f.MemAck) begin
      ack_cnt++;
      addr_log.push_back(f.MemAddr);
      if (!drop) exp_q.push_back(word(f.MemAddr));
      drop = 1'b0;
    end
  endtask
  task automatic branch(input logic [23:0] a);
    f.BranchEn = 1'b1;
    f.BranchAddr = a;
    exp_q.delete();
    if (f.MemRdReq && !f.MemAck) drop = 1'b1;
    cyc();
    f.BranchEn = 1'b0;
  endtask
  task automatic wait_req();
    for (int i = 0; i < 50 && !f.MemRdReq; i++) cyc();
    chk("req_seen", {31'd0, f.MemRdReq}, 32'd1);
  endtask
  task automatic wait_deliv(input int n);
    int t;
    t = deliv + n;
    for (int i = 0; i < 100 && deliv < t; i++) cyc();
    chk("deliv_count", {31'd0, deliv >= t}, 32'd1);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
    chk(tag, exp_q.size(), 32'd0);
  endtask
  initial begin
    int a0, d0;
    logic [23:0] old;
    f.MemAck = 1'b0; f.MemDataIn = '0; f.IRReady = 1'b0; f.BranchEn = 1'b0; f.BranchAddr = '0;
    g.IRReady = 1'b1; g.BranchEn = 1'b0; g.BranchAddr = '0;
    cyc(); cyc();
    chk("rst_req", {31'd0, f.MemRdReq}, 32'd0);
    chk("rst_addr", f.MemAddr, 32'd0);
    chk("rst_iren", {31'd0, f.IRInEn}, 32'd0);
    chk("rst_irdata", f.IRDataOut, 32'd0);
    chk("rst_pc", f.PCOut, 32'd0);
    reset = 1'b0;
    f.IRReady = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 60 && ack_cnt < 3; i++) cyc();
    cyc();
    chk("t1_pc3", f.PCOut, 32'd3);
    chk("t1_addr0", addr_log[0], 32'd0);
    chk("t1_addr1", addr_log[1], 32'd1);
    chk("t1_addr2", addr_log[2], 32'd2);
    auto_ack = 1'b0;
    drain("t1_drain");
    chk("t1_deliv", deliv, 32'd3);
    f.IRReady = 1'b0;
    a0 = ack_cnt;
    d0 = deliv;
    auto_ack = 1'b1;
    repeat (10) cyc();
    chk("t2_acks", ack_cnt - a0, DEPTH);
    chk("t2_no_irinen", deliv - d0, 32'd0);
    chk("t2_req_stopped", {31'd0, f.MemRdReq}, 32'd0);
    auto_ack = 1'b0;
    f.IRReady = 1'b1;
    wait_deliv(DEPTH);
    chk("t2_none_lost", exp_q.size(), 32'd0);
    wait_req();
    old = f.MemAddr;
    branch(24'h00_0100);
    chk("t3_hold_addr", f.MemAddr, old);
    chk("t3_hold_req", {31'd0, f.MemRdReq}, 32'd1);
    chk("t3_pc", f.PCOut, 32'h100);
    addr_log.delete();
    auto_ack = 1'b1;
    wait_deliv(1);
    chk("t3_first_word", last_ir, word(24'h00_0100));
    chk("t3_next_addr", addr_log[1], 32'h100);
    auto_ack = 1'b0;
    drain("t3_drain");
    wait_req();
    f.MemAck = 1'b1;
    f.MemDataIn = word(f.MemAddr);
    branch(24'h00_0200);
    chk("t4_no_irinen", {31'd0, f.IRInEn}, 32'd0);
    chk("t4_pc", f.PCOut, 32'h200);
    chk("t4_idle", {31'd0, f.MemRdReq}, 32'd0);
    auto_ack = 1'b1;
    wait_deliv(1);
    chk("t4_first_word", last_ir, word(24'h00_0200));
    auto_ack = 1'b0;
    drain("t4_drain");
    chk("t5_count", {31'd0, g_log.size() >= 2}, 32'd1);
    chk("t5_addr0", g_log[0], 32'hFF_FFFF);
    chk("t5_addr1", g_log[1], 32'd0);
    wait_req();
    reset = 1'b1;
    cyc();
    chk("t6_req", {31'd0, f.MemRdReq}, 32'd0);
    chk("t6_pc", f.PCOut, 32'd0);
    chk("t6_irinen", {31'd0, f.IRInEn}, 32'd0);
    exp_q.delete();
    drop = 1'b0;
    reset = 1'b0;
    f.MemAck = 1'b1;
    cyc();
    chk("t6_stray_pc", f.PCOut, 32'd0);
    chk("t6_refetch", {31'd0, f.MemRdReq}, 32'd1);
    chk("t6_refetch_addr", f.MemAddr, 32'd0);
    cyc();
    chk("t6_still_req", {31'd0, f.MemRdReq}, 32'd1);
    auto_ack = 1'b1;
    wait_deliv(1);
    chk("t6_first_word", last_ir, word(24'h0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
